reg_file: RTL and testbench

32 x 32-bit general-purpose register file for the single-cycle 31-instruction MIPS core. It sits directly downstream of the write-address selector, which chooses between rd, rt and $31 for jal. It consumes that selector's 5-bit output as its write address. It provides two combinational read ports for the decode/ALU path, a debug read port, and a committed-write counter for bring-up.

---
 rtl/cpu31_pkg.sv | 18 +
 rtl/reg_read_port.sv | 33 +++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu31_pkg.sv
// Shared definitions for the 31-instruction single-cycle MIPS core:
// datapath widths, special register numbers and write-address select codes.
package cpu31_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // $0 is hardwired to zero; $31 receives the jal return address
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Write-address selector encodings, shared with controller and selector
    typedef logic [1:0] wa_sel_t;
    localparam wa_sel_t WA_SEL_RD = 2'b00;
    localparam wa_sel_t WA_SEL_RT = 2'b01;
    localparam wa_sel_t WA_SEL_RA = 2'b10;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: $0 reads as zero, optional
// same-cycle forwarding of the write-back value being committed this edge.
module reg_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_commit,
    output logic [DATA_W-1:0] o_rdata
);

    logic w_is_zero;
    logic w_hit;

    // i_commit already excludes waddr==0, so a hit can never target $0
    assign w_is_zero = (i_raddr == '0);
    assign w_hit     = (BYPASS != 0) && i_commit && (i_raddr == i_waddr);

    // Select zero, forwarded write data, or the stored value
    always_comb begin
        o_rdata = i_regs[i_raddr];
        if (w_is_zero) begin
            o_rdata = '0;
        end else if (w_hit) begin
            o_rdata = i_wdata;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports with optional
// write-to-read forwarding, an unbypassed debug port, and a commit counter.
module reg_file #(
    parameter int DATA_W = cpu31_pkg::DATA_W,
    parameter int ADDR_W = cpu31_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_cnt
);

    import cpu31_pkg::*;

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [31:0]       r_wr_cnt;
    logic              w_commit;

    // A write commits only outside reset, while enabled, and never to $0
    assign w_commit = !rst && ena && we && (waddr != ADDR_W'(REG_ZERO));

    // Register array and commit counter; reset clears everything and wins over writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            r_regs[waddr] <= wdata;
            r_wr_cnt      <= r_wr_cnt + 32'd1;
        end
    end

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .i_raddr  (raddr1),
        .i_regs   (r_regs),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_commit (w_commit),
        .o_rdata  (rdata1)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd2 (
        .i_raddr  (raddr2),
        .i_regs   (r_regs),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_commit (w_commit),
        .o_rdata  (rdata2)
    );

    // Debug view shows committed state only; $0 is never written so it reads zero
    assign dbg_data = r_regs[dbg_addr];
    assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_reg_file.sv
// Directed checks for reg_file, run on a forwarding and a non-forwarding
// instance driven by the same stimulus.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  dbg_addr;

    logic [31:0] b_rdata1, b_rdata2, b_dbg_data, b_wr_cnt;
    logic [31:0] n_rdata1, n_rdata2, n_dbg_data, n_wr_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (b_rdata1),
        .rdata2   (b_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (b_dbg_data),
        .wr_cnt   (b_wr_cnt)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (n_rdata1),
        .rdata2   (n_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (n_dbg_data),
        .wr_cnt   (n_wr_cnt)
    );

    // waddr must be known whenever a write can commit
    always @(posedge clk) begin
        if (ena === 1'b1 && we === 1'b1) begin
            assert (!$isunknown(waddr))
                else $error("FAIL waddr_xz: waddr=%b with we=1 ena=1", waddr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One committed (or attempted) write: drive at negedge, release after the edge
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        rst = 1'b1; ena = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        raddr1 = 5'd5; raddr2 = 5'd0; dbg_addr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; we = 1'b0;
        #1;
        chk("reset_cnt_byp", b_wr_cnt, 32'd0);
        chk("reset_cnt_nob", n_wr_cnt, 32'd0);
        chk("reset_dbg5", b_dbg_data, 32'd0);
        chk("reset_rd1_5", b_rdata1, 32'd0);

        // basic write of $8
        raddr1 = 5'd8;
        @(negedge clk);
        we = 1'b1; waddr = 5'd8; wdata = 32'hDEAD_BEEF;
        #1;
        chk("byp_same_cycle_8", b_rdata1, 32'hDEAD_BEEF);
        chk("nob_before_edge_8", n_rdata1, 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("nob_after_edge_8", n_rdata1, 32'hDEAD_BEEF);
        chk("byp_after_edge_8", b_rdata1, 32'hDEAD_BEEF);
        chk("cnt_after_w8", b_wr_cnt, 32'd1);

        // $0 immunity
        raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        #1;
        chk("zero_byp_rd1_pre", b_rdata1, 32'd0);
        chk("zero_byp_rd2_pre", b_rdata2, 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("zero_rd1_post", b_rdata1, 32'd0);
        chk("zero_dbg_post", b_dbg_data, 32'd0);
        chk("zero_cnt", b_wr_cnt, 32'd1);

        // jal link write to $31, both ports forwarding
        raddr1 = 5'd31; raddr2 = 5'd31; dbg_addr = 5'd31;
        @(negedge clk);
        we = 1'b1; waddr = 5'd31; wdata = 32'h0040_0008;
        #1;
        chk("byp31_rd1", b_rdata1, 32'h0040_0008);
        chk("byp31_rd2", b_rdata2, 32'h0040_0008);
        chk("byp31_dbg", b_dbg_data, 32'd0);
        chk("nob31_rd1_pre", n_rdata1, 32'd0);
        chk("nob31_rd2_pre", n_rdata2, 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("nob31_rd1_post", n_rdata1, 32'h0040_0008);
        chk("dbg31_post", b_dbg_data, 32'h0040_0008);
        chk("cnt_after_w31", n_wr_cnt, 32'd2);

        // per-port independence: only port 2 matches waddr
        raddr1 = 5'd31; raddr2 = 5'd8;
        @(negedge clk);
        we = 1'b1; waddr = 5'd8; wdata = 32'h0000_55AA;
        #1;
        chk("indep_rd1_stored", b_rdata1, 32'h0040_0008);
        chk("indep_rd2_bypass", b_rdata2, 32'h0000_55AA);
        chk("indep_nob_rd2", n_rdata2, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("cnt_after_w8b", b_wr_cnt, 32'd3);

        // enable gating
        do_write(5'd5, 32'hA5A5_0005);
        raddr1 = 5'd5; dbg_addr = 5'd5;
        @(negedge clk);
        ena = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h0000_1234;
        #1;
        chk("ena0_no_bypass", b_rdata1, 32'hA5A5_0005);
        @(posedge clk);
        #1;
        we = 1'b0; ena = 1'b1;
        #1;
        chk("ena0_reg5_hold", b_dbg_data, 32'hA5A5_0005);
        chk("ena0_cnt_hold", b_wr_cnt, 32'd4);

        // fill $1..$31 and read back through both ports
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'hC0DE_0000 | 32'(i));
        #1;
        chk("fill_cnt", b_wr_cnt, 32'd35);
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            exp_d = 32'hC0DE_0000 | 32'(i);
            chk("fill_rd1", b_rdata1, exp_d);
            chk("fill_rd2", n_rdata2, (i == 31) ? 32'd0 : (32'hC0DE_0000 | 32'(31 - i)));
        end

        // reset with a valid write pending: write discarded, all cleared
        raddr1 = 5'd5;
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h0000_1234;
        #1;
        chk("rst_no_bypass", b_rdata1, 32'hC0DE_0005);
        @(posedge clk);
        #1;
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("rst_clear_dbg", b_dbg_data, 32'd0);
        end
        chk("rst_cnt_byp", b_wr_cnt, 32'd0);
        chk("rst_cnt_nob", n_wr_cnt, 32'd0);

        // counter wrap via backdoor preload
        @(negedge clk);
        force u_byp.r_wr_cnt = 32'hFFFF_FFFF;
        #1;
        release u_byp.r_wr_cnt;
        #1;
        chk("wrap_preload", b_wr_cnt, 32'hFFFF_FFFF);
        do_write(5'd0, 32'h0000_0007);
        #1;
        chk("wrap_zero_not_counted", b_wr_cnt, 32'hFFFF_FFFF);
        do_write(5'd3, 32'h0000_0007);
        #1;
        chk("wrap_to_zero", b_wr_cnt, 32'd0);
        chk("nob_cnt_one", n_wr_cnt, 32'd1);
        raddr1 = 5'd3;
        #1;
        chk("wrap_reg3", n_rdata1, 32'h0000_0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
